pc_unit_ras: RTL and testbench
==============================

// Module: pc_unit_ras
// PURPOSE
//  Parametrised program-counter unit with a return-address stack (RAS) and fetch stall.
//  Holds the architectural fetch PC and selects next PC from pc+4, PC-relative immediate,
//  ALU result or the RAS top, with a stall input so fetch can be held.
//  Sits at the head of the fetch path and drives instruction-memory address and link value.
// PARAMETERS
//  XLEN          32           PC / operand width in bits (>=8)
//  RESET_VECTOR  32'h0        PC value loaded on reset
//  RAS_DEPTH     4            return-address stack entries (power of 2, >=2)
//  TRAP_VECTOR   32'h100      misaligned-target redirect (used only with PC_MISALIGN_TRAP_EN)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-low reset
//  stall        in   1        1: hold PC and RAS this cycle
//  jump         in   1        1: take redirect selected by jumpSel
//  jumpSel      in   2        0 PC4, 1 IMM, 2 ALU, 3 RAS (predicted return)
//  call         in   1        with jump: push pc4 onto RAS (JAL/JALR with rd=ra)
//  AluOut       in   XLEN     ALU target (JALR)
//  PCImm        in   XLEN     PC+imm target (JAL/branch)
//  pc           out  XLEN     current fetch PC (registered)
//  pc4          out  XLEN     pc+4, combinational, link value
//  ras_count    out  $clog2(RAS_DEPTH)+1  valid RAS entries
//  misalign     out  1        1-cycle pulse on trapped redirect (0 if macro off)
// BEHAVIOUR
//  - Reset (rst=0, async): pc=RESET_VECTOR, ras_count=0, RAS pointer=0, misalign=0; RAS data undefined.
//  - pc4 = pc+4 mod 2^XLEN; PC wraps at top of address space, no flag.
//  - Update on rising clk, priority: stall > jump > sequential.
//  - stall=1: pc, RAS, count hold; jump/call ignored (caller re-presents them).
//  - stall=0, jump=0: pc<=pc4; RAS untouched; call ignored.
//  - stall=0, jump=1: next = sel 0 pc4 | 1 PCImm | 2 AluOut | 3 RAS top.
//  - sel 3 with ras_count==0: next = AluOut (fallback), no pop.
//  - sel 3 with ras_count>0: pop; count-1; pointer-1 mod RAS_DEPTH.
//  - call=1 (jump=1, stall=0): push pc4 (link of current pc); count+1 saturating at RAS_DEPTH;
//    when full, newest overwrites oldest (circular), count stays RAS_DEPTH.
//  - call with sel 3 same cycle: target = old top; top slot replaced by pc4; count unchanged.
//  - Latency: redirect visible on pc one cycle after the jump cycle; no bubbles inserted.
//  - Reset deasserted mid-stall: first edge after release acts on current inputs normally.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined: on any taken redirect (sel 1..3) with next[1:0]!=0,
//   pc<=TRAP_VECTOR and misalign=1 for that cycle; RAS push/pop of that cycle still applies.
//  Undefined: target loaded verbatim, misalign tied 0, TRAP_VECTOR unused.
// STRUCTURE
//  - Shared package (parameters.vh): jump-select constants PJumpPc4=0, PJumpImm=1,
//    PJumpAlu=2, PJumpRas=3; XLEN default.
//  - Sub-module return_addr_stack: circular array, pointer, count, push/pop/replace,
//    top output; instanced once. Top module holds PC register, next-PC mux, trap check.
// TESTING
//  1 rst=0 mid-run -> pc=0x0, ras_count=0 immediately; release, 3 clks -> pc=0xC.
//  2 pc=0x10, jump=1 sel=1 PCImm=0x40 call=1 -> pc=0x40, ras_count=1; later sel=3 -> pc=0x14, count=0.
//  3 stall=1 for 2 clks with jump=1 sel=2 AluOut=0x80 -> pc holds, count holds; stall=0 -> pc=0x80.
//  4 5 calls at pc 0x0,0x20,0x40,0x60,0x80 (RAS_DEPTH=4) -> count=4; 4 returns give 0x84,0x64,0x44,0x24;
//    5th return (empty) -> pc=AluOut.
//  5 pc=32'hFFFF_FFFC, jump=0 -> pc=0x0 (wrap); sel=3 with call=1 -> target old top, count unchanged.
//  6 macro on: sel=2 AluOut=0x42 -> pc=TRAP_VECTOR, misalign pulse 1 clk; macro off -> pc=0x42, misalign=0.

Source files
------------

// File: rtl/pc_unit_ras_pkg.sv
// Shared definitions for the program-counter unit: jump-select encoding,
// default datapath width and a small alignment helper.
// Optional feature macro used by the top: PC_MISALIGN_TRAP_EN.
package pc_unit_ras_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      PJumpPc4 = 2'd0,
      PJumpImm = 2'd1,
      PJumpAlu = 2'd2,
      PJumpRas = 2'd3
   } jump_sel_e;

   function automatic logic isMisaligned(input logic [1:0] lowBits);
      return lowBits != 2'b00;
   endfunction

endpackage

// File: rtl/pc_unit_ras_return_addr_stack.sv
// Circular return-address stack. Pushing onto a full stack silently
// overwrites the oldest entry. A simultaneous push and pop replaces the top
// entry in place, so pointer and count stay put. Entry data is not reset.
// Callers must only assert pop_i while count_o is non-zero.
module return_addr_stack
   import pc_unit_ras_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [XLEN-1:0]            pushData_i,
   output logic [XLEN-1:0]            top_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PtrW = $clog2(DEPTH);
   localparam int CntW = PtrW + 1;

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [PtrW-1:0] topIdx;

   assign topIdx  = ptr_q - PtrW'(1);
   assign top_o   = mem_q[topIdx];
   assign count_o = count_q;

   // Next pointer and occupancy: push grows (saturating), pop shrinks, both together is a replace
   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      if (push_i && !pop_i) begin
         ptr_d = ptr_q + PtrW'(1);
         if (count_q != CntW'(DEPTH)) begin
            count_d = count_q + CntW'(1);
         end
      end else if (pop_i && !push_i) begin
         ptr_d   = ptr_q - PtrW'(1);
         count_d = count_q - CntW'(1);
      end
   end

   // Entry storage: a replace writes the current top slot, a plain push writes the next free slot
   always_ff @(posedge clk) begin
      if (push_i && pop_i) begin
         mem_q[topIdx] <= pushData_i;
      end else if (push_i) begin
         mem_q[ptr_q] <= pushData_i;
      end
   end

   // Pointer and count registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pc_unit_ras.sv
// Program-counter unit: holds the fetch PC, selects the next PC from pc+4,
// a PC-relative immediate, the ALU result or the return-address stack, and
// supports holding fetch with stall. Priority is stall > jump > sequential.
// Optional macro PC_MISALIGN_TRAP_EN: a taken redirect to a target that is
// not word aligned loads TRAP_VECTOR instead and pulses misalign for one cycle.
module pc_unit_ras
   import pc_unit_ras_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              RAS_DEPTH    = 4,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        stall,
   input  logic                        jump,
   input  logic [1:0]                  jumpSel,
   input  logic                        call,
   input  logic [XLEN-1:0]             AluOut,
   input  logic [XLEN-1:0]             PCImm,
   output logic [XLEN-1:0]             pc,
   output logic [XLEN-1:0]             pc4,
   output logic [$clog2(RAS_DEPTH):0]  ras_count,
   output logic                        misalign
);

   localparam int CntW = $clog2(RAS_DEPTH) + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic            misalign_q, misalign_d;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] rasTop;
   logic [CntW-1:0] rasCount;
   logic            rasPush, rasPop;
   jump_sel_e       sel;

   assign sel       = jump_sel_e'(jumpSel);
   assign pc4       = pc_q + XLEN'(4);
   assign pc        = pc_q;
   assign ras_count = rasCount;
   assign misalign  = misalign_q;

`ifndef PC_MISALIGN_TRAP_EN
   logic [XLEN-1:0] unusedTrapVector;
   assign unusedTrapVector = TRAP_VECTOR;
`endif

   // Redirect target selection and stack control; an empty stack falls back to the ALU target
   always_comb begin
      target  = pc4;
      rasPush = 1'b0;
      rasPop  = 1'b0;
      case (sel)
         PJumpPc4: target = pc4;
         PJumpImm: target = PCImm;
         PJumpAlu: target = AluOut;
         PJumpRas: target = (rasCount != '0) ? rasTop : AluOut;
         default:  target = pc4;
      endcase
      if (!stall && jump) begin
         rasPush = call;
         rasPop  = (sel == PJumpRas) && (rasCount != '0);
      end
   end

   // Next PC: hold on stall, step on no jump, otherwise take the redirect (optionally trapped)
   always_comb begin
      pc_d       = pc_q;
      misalign_d = 1'b0;
      if (!stall) begin
         if (!jump) begin
            pc_d = pc4;
         end else begin
            pc_d = target;
`ifdef PC_MISALIGN_TRAP_EN
            if ((sel != PJumpPc4) && isMisaligned(target[1:0])) begin
               pc_d       = TRAP_VECTOR;
               misalign_d = 1'b1;
            end
`endif
         end
      end
   end

   // PC and misalign pulse registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= RESET_VECTOR;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   return_addr_stack #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) uRas (
      .clk        (clk),
      .rst        (rst),
      .push_i     (rasPush),
      .pop_i      (rasPop),
      .pushData_i (pc4),
      .top_o      (rasTop),
      .count_o    (rasCount)
   );

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: directed vector table, hand-written
// reset and misalignment sequences, and randomized traffic compared against
// a queue-based reference model.
module tb_pc_unit_ras;

   localparam logic [31:0] TRAP = 32'h100;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        jump;
   logic [1:0]  jumpSel;
   logic        call;
   logic [31:0] AluOut;
   logic [31:0] PCImm;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic [2:0]  ras_count;
   logic        misalign;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mPc;
   logic        mMis;
   logic [31:0] mQ[$];

   typedef struct {
      logic        st;
      logic        j;
      logic [1:0]  sel;
      logic        c;
      logic [31:0] alu;
      logic [31:0] imm;
      logic [31:0] expPc;
      int          expCnt;
   } vec_t;

   vec_t vecs[$];

   pc_unit_ras #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0),
      .RAS_DEPTH    (4),
      .TRAP_VECTOR  (TRAP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .jump      (jump),
      .jumpSel   (jumpSel),
      .call      (call),
      .AluOut    (AluOut),
      .PCImm     (PCImm),
      .pc        (pc),
      .pc4       (pc4),
      .ras_count (ras_count),
      .misalign  (misalign)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, ".pc"}, pc, mPc);
      checkVal({tag, ".pc4"}, pc4, mPc + 32'd4);
      checkVal({tag, ".count"}, 32'(ras_count), 32'(mQ.size()));
      checkVal({tag, ".misalign"}, 32'(misalign), 32'(mMis));
   endtask

   task automatic modelReset();
      mPc  = 32'h0;
      mMis = 1'b0;
      mQ.delete();
   endtask

   task automatic modelStep(input logic st, input logic j, input logic [1:0] sel,
                            input logic c, input logic [31:0] alu, input logic [31:0] imm);
      logic [31:0] link;
      logic [31:0] tgt;
      logic        popping;
      mMis = 1'b0;
      if (st) return;
      link = mPc + 32'd4;
      if (!j) begin
         mPc = link;
         return;
      end
      popping = 1'b0;
      case (sel)
         2'd0: tgt = link;
         2'd1: tgt = imm;
         2'd2: tgt = alu;
         default: begin
            if (mQ.size() > 0) begin
               tgt     = mQ[$];
               popping = 1'b1;
            end else begin
               tgt = alu;
            end
         end
      endcase
      if (c && popping) begin
         mQ[mQ.size()-1] = link;
      end else if (popping) begin
         void'(mQ.pop_back());
      end else if (c) begin
         mQ.push_back(link);
         if (mQ.size() > 4) void'(mQ.pop_front());
      end
`ifdef PC_MISALIGN_TRAP_EN
      if (sel != 2'd0 && tgt[1:0] != 2'b00) begin
         tgt  = TRAP;
         mMis = 1'b1;
      end
`endif
      mPc = tgt;
   endtask

   task automatic applyStimulus(input logic st, input logic j, input logic [1:0] sel,
                                input logic c, input logic [31:0] alu, input logic [31:0] imm);
      stall   = st;
      jump    = j;
      jumpSel = sel;
      call    = c;
      AluOut  = alu;
      PCImm   = imm;
      modelStep(st, j, sel, c, alu, imm);
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic vec_t mk(input logic st, input logic j, input logic [1:0] sel, input logic c,
                               input logic [31:0] alu, input logic [31:0] imm,
                               input logic [31:0] expPc, input int expCnt);
      vec_t v;
      v.st = st; v.j = j; v.sel = sel; v.c = c;
      v.alu = alu; v.imm = imm; v.expPc = expPc; v.expCnt = expCnt;
      return v;
   endfunction

   // Main test sequence
   initial begin
      logic        rs, rj, rc;
      logic [1:0]  rsel;
      logic [31:0] ralu, rimm;

      rst = 1'b0; stall = 1'b0; jump = 1'b0; jumpSel = 2'd0; call = 1'b0;
      AluOut = '0; PCImm = '0;
      modelReset();

      vecs.push_back(mk(0,0,2'd0,0,32'h0,32'h0,32'h4,0));
      vecs.push_back(mk(0,0,2'd0,0,32'h0,32'h0,32'h8,0));
      vecs.push_back(mk(0,0,2'd0,0,32'h0,32'h0,32'hC,0));
      vecs.push_back(mk(0,0,2'd0,0,32'h0,32'h0,32'h10,0));
      vecs.push_back(mk(0,1,2'd1,1,32'h0,32'h40,32'h40,1));
      vecs.push_back(mk(0,0,2'd0,0,32'h0,32'h0,32'h44,1));
      vecs.push_back(mk(0,1,2'd3,0,32'h0,32'h0,32'h14,0));
      vecs.push_back(mk(1,1,2'd2,0,32'h80,32'h0,32'h14,0));
      vecs.push_back(mk(1,1,2'd2,0,32'h80,32'h0,32'h14,0));
      vecs.push_back(mk(0,1,2'd2,0,32'h80,32'h0,32'h80,0));
      vecs.push_back(mk(0,1,2'd2,0,32'h0,32'h0,32'h0,0));
      vecs.push_back(mk(0,1,2'd1,1,32'h0,32'h20,32'h20,1));
      vecs.push_back(mk(0,1,2'd1,1,32'h0,32'h40,32'h40,2));
      vecs.push_back(mk(0,1,2'd1,1,32'h0,32'h60,32'h60,3));
      vecs.push_back(mk(0,1,2'd1,1,32'h0,32'h80,32'h80,4));
      vecs.push_back(mk(0,1,2'd1,1,32'h0,32'h200,32'h200,4));
      vecs.push_back(mk(0,1,2'd3,0,32'h300,32'h0,32'h84,3));
      vecs.push_back(mk(0,1,2'd3,0,32'h300,32'h0,32'h64,2));
      vecs.push_back(mk(0,1,2'd3,0,32'h300,32'h0,32'h44,1));
      vecs.push_back(mk(0,1,2'd3,0,32'h300,32'h0,32'h24,0));
      vecs.push_back(mk(0,1,2'd3,0,32'h300,32'h0,32'h300,0));
      vecs.push_back(mk(0,1,2'd2,0,32'hFFFF_FFFC,32'h0,32'hFFFF_FFFC,0));
      vecs.push_back(mk(0,0,2'd0,0,32'h0,32'h0,32'h0,0));
      vecs.push_back(mk(0,1,2'd1,1,32'h0,32'h500,32'h500,1));
      vecs.push_back(mk(0,1,2'd3,1,32'h0,32'h0,32'h4,1));
      vecs.push_back(mk(0,1,2'd3,0,32'h0,32'h0,32'h504,0));

      #12;
      checkVal("reset.pc", pc, 32'h0);
      checkOutput("reset");
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].st, vecs[i].j, vecs[i].sel, vecs[i].c, vecs[i].alu, vecs[i].imm);
         checkVal($sformatf("vec%0d.pc", i), pc, vecs[i].expPc);
         checkVal($sformatf("vec%0d.count", i), 32'(ras_count), 32'(vecs[i].expCnt));
         checkVal($sformatf("vec%0d.misalign", i), 32'(misalign), 32'h0);
      end

      applyStimulus(0, 1, 2'd2, 0, 32'h42, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
      checkVal("trap.pc", pc, TRAP);
      checkVal("trap.misalign", 32'(misalign), 32'h1);
`else
      checkVal("trap.pc", pc, 32'h42);
      checkVal("trap.misalign", 32'(misalign), 32'h0);
`endif
      applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
      checkVal("trapAfter.misalign", 32'(misalign), 32'h0);
      checkOutput("trapAfter");

      for (int i = 0; i < 400; i++) begin
         rs   = ($urandom_range(0, 4) == 0);
         rj   = ($urandom_range(0, 9) < 4);
         rc   = ($urandom_range(0, 9) < 3);
         rsel = 2'($urandom_range(0, 3));
         ralu = $urandom;
         rimm = $urandom;
         if ($urandom_range(0, 3) != 0) ralu[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) rimm[1:0] = 2'b00;
         applyStimulus(rs, rj, rsel, rc, ralu, rimm);
         checkOutput($sformatf("rand%0d", i));
      end

      stall = 1'b1; jump = 1'b1; jumpSel = 2'd2; AluOut = 32'h80;
      rst = 1'b0;
      modelReset();
      #1;
      checkVal("midReset.pc", pc, 32'h0);
      checkVal("midReset.count", 32'(ras_count), 32'h0);
      checkVal("midReset.misalign", 32'(misalign), 32'h0);
      @(posedge clk);
      @(negedge clk);
      checkVal("midResetHeld.pc", pc, 32'h0);
      rst = 1'b1;
      applyStimulus(1, 1, 2'd2, 0, 32'h80, 32'h0);
      checkVal("releaseStall.pc", pc, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
      checkVal("releaseSeq.pc", pc, 32'hC);
      checkOutput("releaseSeq");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
